// File: rtl/debounce_multi.sv
// debounce_multi: CH-channel sync+debounce of bin into bout, with one-cycle press/rel(release)/long_press pulses
module debounce_multi #(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W = 20,
  parameter int DB_TICKS = 524288,
  parameter int LP_W = 26,
  parameter int LP_TICKS = 50000000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] bin,
  output logic [CH-1:0] bout,
  output logic [CH-1:0] press,
  output logic [CH-1:0] rel,
  output logic [CH-1:0] long_press
);
  localparam logic INACT = ACTIVE_LOW != 0;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_TICKS - 1);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic lvl, flip, b, p, r;
    assign lvl = sync[SYNC_STAGES-1] ^ INACT;
    assign flip = lvl != b && cnt == DB_LAST;
    always_ff @(posedge clk)
      if (rst) begin
        sync <= {SYNC_STAGES{INACT}};
        cnt <= '0;
        b <= 1'b0;
        p <= 1'b0;
        r <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], bin[i]};
        cnt <= (lvl == b || flip) ? '0 : cnt + CNT_W'(1);
        b <= b ^ flip;
        p <= flip & lvl;
        r <= flip & ~lvl;
      end
    assign bout[i] = b;
    assign press[i] = p;
    assign rel[i] = r;
    if (LP_TICKS > 0) begin : g_lp
      localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_TICKS - 1);
      logic [LP_W-1:0] lp_cnt;
      logic fired, lp;
      always_ff @(posedge clk)
        if (rst || !b) begin
          lp_cnt <= '0;
          fired <= 1'b0;
          lp <= 1'b0;
        end else begin
          lp <= !fired && lp_cnt == LP_LAST && !flip;
          fired <= fired | (lp_cnt == LP_LAST);
          lp_cnt <= lp_cnt + LP_W'(lp_cnt != LP_LAST && !fired);
        end
      assign long_press[i] = lp;
    end else begin : g_nolp
      assign long_press[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: randomized scoreboard bench for debounce_multi against a window-based reference model
module tb_debounce_multi;
  localparam int S = 3;
  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0] bout, press, rel, lp;
  } ev_t;
  logic clk = 0, rst = 1;
  logic [1:0] b = 2'b11, bn;
  logic [1:0] bout0, press0, rel0, lp0;
  logic [1:0] bout1, press1, rel1, lp1;
  logic [1:0] bout2, press2, rel2, lp2;
  int cyc = 0, total = 0, bad = 0;
  ev_t q0[$], q1[$];
  logic [1:0] xh[$], yh[$];
  int lvl[2][2], pe[2][2];
  assign bn = ~b;
  always #5 clk = ~clk;
  debounce_multi #(.CH(2), .SYNC_STAGES(3), .CNT_W(3), .DB_TICKS(4), .LP_W(4), .LP_TICKS(10), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .bin(b), .bout(bout0), .press(press0), .rel(rel0), .long_press(lp0));
  debounce_multi #(.CH(2), .SYNC_STAGES(3), .CNT_W(3), .DB_TICKS(4), .LP_W(4), .LP_TICKS(10), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .bin(bn), .bout(bout1), .press(press1), .rel(rel1), .long_press(lp1));
  debounce_multi #(.CH(2), .SYNC_STAGES(3), .CNT_W(1), .DB_TICKS(1), .LP_W(1), .LP_TICKS(0), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .bin(b), .bout(bout2), .press(press2), .rel(rel2), .long_press(lp2));
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask
  // reference: a level flips when the last DB synchronised samples all differ from it
  task automatic model(input logic [1:0] x, input bit r);
    logic [1:0] y;
    ev_t e;
    int db, lpt;
    bit acc;
    if (r) begin
      xh.delete();
      yh.delete();
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < 2; c++) begin
          lvl[m][c] = 0;
          pe[m][c] = -1;
        end
      return;
    end
    y = xh.size() >= S ? xh[xh.size() - S] : 2'b00;
    xh.push_back(x);
    yh.push_back(y);
    for (int m = 0; m < 2; m++) begin
      db = m ? 1 : 4;
      lpt = m ? 0 : 10;
      e = '0;
      e.cyc = 16'(cyc);
      for (int c = 0; c < 2; c++) begin
        acc = yh.size() >= db;
        for (int j = 1; j <= db && acc; j++)
          if (int'(yh[yh.size() - j][c]) == lvl[m][c]) acc = 0;
        if (acc) begin
          if (lvl[m][c] == 0) begin
            e.press[c] = 1'b1;
            pe[m][c] = cyc;
          end else begin
            e.rel[c] = 1'b1;
            pe[m][c] = -1;
          end
          lvl[m][c] = 1 - lvl[m][c];
        end else if (lpt > 0 && pe[m][c] >= 0 && cyc - pe[m][c] == lpt)
          e.lp[c] = 1'b1;
        e.bout[c] = lvl[m][c][0];
      end
      if (|{e.press, e.rel, e.lp}) begin
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask
  task automatic step(input logic [1:0] x, input bit r);
    @(negedge clk);
    b = x;
    rst = r;
    @(posedge clk);
    cyc++;
    model(x, r);
  endtask
  task automatic hold(input logic [1:0] x, input int n);
    repeat (n) step(x, 0);
  endtask
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (|{press0, rel0, lp0, press1, rel1, lp1}) begin
        if (q0.size() == 0) chk("extra_event_main", 32'({16'(cyc), bout0, press0, rel0, lp0}), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          chk("event_active_high", 32'({16'(cyc), bout0, press0, rel0, lp0}), 32'(e));
          chk("event_active_low", 32'({16'(cyc), bout1, press1, rel1, lp1}), 32'(e));
        end
      end
      if (|{press2, rel2, lp2}) begin
        if (q1.size() == 0) chk("extra_event_db1", 32'({16'(cyc), bout2, press2, rel2, lp2}), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          chk("event_db1", 32'({16'(cyc), bout2, press2, rel2, lp2}), 32'(e));
        end
      end
    end
  end
  initial begin
    logic [1:0] v;
    step(2'b11, 1);
    step(2'b11, 1);
    #1;
    chk("reset_outputs", 32'({bout0, press0, rel0, lp0, bout1, press1, rel1, lp1, bout2, press2, rel2, lp2}), 32'h0);
    hold(2'b11, 12);
    hold(2'b00, 12);
    hold(2'b01, 12);
    hold(2'b00, 12);
    hold(2'b01, 3);
    hold(2'b00, 5);
    hold(2'b01, 3);
    hold(2'b00, 1);
    hold(2'b01, 3);
    hold(2'b00, 12);
    hold(2'b01, 25);
    hold(2'b00, 12);
    hold(2'b01, 25);
    hold(2'b00, 12);
    hold(2'b10, 12);
    hold(2'b00, 12);
    hold(2'b01, 4);
    step(2'b01, 1);
    hold(2'b01, 12);
    hold(2'b00, 12);
    hold(2'b11, 20);
    hold(2'b00, 12);
    for (int i = 0; i < 300; i++) begin
      v = 2'($urandom);
      hold(v, $urandom_range(1, ($urandom_range(0, 3) == 0) ? 25 : 6));
      if ($urandom_range(0, 40) == 0) step(v, 1);
    end
    hold(2'b00, 30);
    chk("pending_main", q0.size(), 0);
    chk("pending_db1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
